parity_push_adapter: RTL and testbench
======================================

# parity_push_adapter

Producer-side front end for the parity FIFO: accepts raw `DATA_WIDTH`-bit words from an upstream source, appends a parity bit, and drives the FIFO push interface (`push_data`/`push_valid`/`push_grant`). It contains a 2-entry skid buffer, so full throughput is sustained while every output is registered. A parity-error injection input lets benches exercise the downstream parity checker's drop path. The block sits directly in front of the FIFO's push port.

## Interface

- `DATA_WIDTH`, 32, payload width; the output word is `DATA_WIDTH+1` bits.
- `EVEN_ODD`, 0, parity sense: 0 = even (total ones in the output word even); 1 = odd.
- `PARITY_BIT`, 0, parity position: 0 = parity at bit 0, payload in `[DATA_WIDTH:1]`; 1 = parity at bit `DATA_WIDTH`, payload in `[DATA_WIDTH-1:0]`.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data_i`  in  `DATA_WIDTH`  upstream payload.
- `in_valid_i`  in  1  upstream has a word.
- `inject_err_i`  in  1  qualifies `in_data_i`; when high, the parity bit of that word is inverted.
- `in_grant_o`  out  1  the block can accept a word this cycle.
- `push_data_o`  out  `DATA_WIDTH+1`  word with parity, to the FIFO.
- `push_valid_o`  out  1  `push_data_o` is valid.
- `push_grant_i`  in  1  the FIFO accepts a word this cycle.
- `push_count_o`  out  16  count of words transferred to the FIFO.

## Operation

- **Input transfer:** occurs on a rising edge where `in_valid_i && in_grant_o`.
- **Output transfer:** occurs on a rising edge where `push_valid_o && push_grant_i`.
- **Parity generation:**
  - `p = ^in_data_i ^ inject_err_i ^ EVEN_ODD`.
  - The payload and `p` are placed according to `PARITY_BIT`.
  - Parity is computed when the word is accepted and stored with it.
- **Storage:** an output register (OUT) and a skid register (SKID).
- **States:**
  - EMPTY: nothing held.
  - ONE: OUT valid.
  - TWO: OUT and SKID both valid.
- **State transitions** (in = input transfer, out = output transfer):
  - EMPTY, in → ONE; the word is loaded into OUT.
  - ONE, in and not out → TWO; the word is loaded into SKID.
  - ONE, in and out → ONE; the word is loaded into OUT.
  - ONE, out and not in → EMPTY.
  - TWO, out → ONE; SKID moves to OUT. Input is impossible in TWO (`in_grant_o` = 0).
  - All other cases hold the current state.
- **Ordering:** strict FIFO. A word in SKID is always older than any newly accepted word.
- **`push_count_o`:**
  - Increments by 1 on each output transfer.
  - Wraps from 0xFFFF to 0x0000.
  - Is not saturating.
- **Stability:** while `push_valid_o` = 1 and `push_grant_i` = 0, `push_data_o` holds stable. The FIFO may withhold grant indefinitely.
- **Ignored inputs:** `in_data_i` and `inject_err_i` are ignored when no input transfer occurs.

## Timing

- **Reset values** (while `rst` = 1, asynchronous):
  - state = EMPTY.
  - `push_valid_o` = 0, `push_data_o` = 0, `in_grant_o` = 0, `push_count_o` = 0.
  - SKID is cleared to 0.
- **After reset:** `in_grant_o` rises on the first rising edge after `rst` deasserts.
- **Reset mid-operation:** contents of OUT and SKID are discarded immediately, and outputs take their reset values without waiting for a clock edge.
- **Registered outputs:** all outputs are registered. There is no combinational path from `push_grant_i` to `in_grant_o`, or from `in_valid_i` to `push_valid_o`.
- **Latency:** one cycle from input transfer to `push_valid_o`. A word accepted at edge N appears on `push_data_o` after edge N.
- **`in_grant_o`:** equals 1 in EMPTY and ONE, and 0 in TWO. It updates with the state register.
- **Throughput:** one word per cycle sustained whenever `push_grant_i` is held high.
- **Simultaneous events in ONE:** an input transfer and an output transfer on the same edge leave the occupancy unchanged.
- **Back-pressure:** a one-cycle deassertion of `push_grant_i` during streaming drops no word. The skid absorbs the in-flight word, and `in_grant_o` drops for at most the cycles spent in TWO.

## Test plan

- **Reset:**
  - Stimulus: assert `rst` mid-stream with two words held.
  - Response: `push_valid_o` = 0 and `push_count_o` = 0 immediately, without a clock edge.
  - After release: `in_grant_o` = 1 one edge later, and no held word reappears.
- **Parity encoding** (`DATA_WIDTH`=32, `PARITY_BIT`=0, `EVEN_ODD`=0):
  - `in_data_i` = 0x00000003 → `push_data_o` = 33'h6.
  - `in_data_i` = 0x00000001 → `push_data_o` = 33'h3.
  - With `PARITY_BIT`=1: `in_data_i` = 0x00000001 → `push_data_o` = 33'h1_0000_0001.
- **Error injection:**
  - Stimulus: `in_data_i` = 0x00000003 with `inject_err_i` = 1 (`PARITY_BIT`=0, `EVEN_ODD`=0).
  - Response: `push_data_o` = 33'h7.
  - `inject_err_i` = 1 while no input transfer occurs has no effect on later words.
- **Back-pressure:**
  - Stimulus: stream 0x10, 0x11, 0x12, … continuously; drop `push_grant_i` for cycles 3–5.
  - Response: `in_grant_o` goes low once TWO is reached and recovers afterward.
  - Output order is exactly 0x10, 0x11, …, with no loss or duplication.
  - `push_count_o` equals the number of granted words.
- **Full throughput:**
  - Stimulus: `push_grant_i` = 1 and `in_valid_i` = 1 for 100 cycles.
  - Response: 99 output transfers, state never reaches TWO, `in_grant_o` stays 1.
- **Counter wrap:**
  - Stimulus: 65537 transfers.
  - Response: `push_count_o` = 0x0001.

Source files
------------

// File: rtl/parity_push_adapter.sv
// ---------------------------------------------------------------------------
// parity_push_adapter
//
// Producer-side front end for the parity FIFO. Raw payload words from an
// upstream source get a parity bit appended when they are accepted. The
// result is presented on the FIFO push interface. A two-entry skid buffer
// (OUT + SKID) sustains one word per cycle while keeping every output
// registered.
//
// Parameters:
//   DATA_WIDTH  payload width; the pushed word is DATA_WIDTH+1 bits
//   EVEN_ODD    0 = even parity over the whole pushed word, 1 = odd
//   PARITY_BIT  0 = parity at bit 0 with the payload above it
//               1 = parity at bit DATA_WIDTH with the payload below it
//
// Ports:
//   clk           single clock, rising-edge
//   rst           asynchronous, active-high reset
//   in_data_i     upstream payload
//   in_valid_i    upstream has a word
//   inject_err_i  invert the parity bit of the word accepted this cycle
//   in_grant_o    the block can accept a word this cycle
//   push_data_o   word plus parity, to the FIFO
//   push_valid_o  push_data_o is valid
//   push_grant_i  the FIFO takes the word this cycle
//   push_count_o  wrapping count of words handed to the FIFO
// ---------------------------------------------------------------------------
module parity_push_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  inject_err_i,
  output logic                  in_grant_o,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [15:0]           push_count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q, state_next;
  logic [DATA_WIDTH:0]   out_q, out_next;
  logic [DATA_WIDTH:0]   skid_q, skid_next;
  logic [15:0]           count_q, count_next;
  logic                  valid_q, valid_next;
  logic                  grant_q, grant_next;

  logic                  in_xfer;
  logic                  out_xfer;
  logic [DATA_WIDTH:0]   new_word;

  // Parity is fixed at acceptance time and travels with the word. That way a
  // later change of inject_err_i cannot disturb a word already held.
  function automatic logic [DATA_WIDTH:0] encode(input logic [DATA_WIDTH-1:0] d,
                                                 input logic inj);
    logic p;
    p = (^d) ^ inj ^ (EVEN_ODD != 0);
    if (PARITY_BIT == 0) begin
      return {d, p};
    end else begin
      return {p, d};
    end
  endfunction

  // Handshakes are formed only from registered outputs. Because of this, no
  // combinational path runs from push_grant_i to in_grant_o.
  assign in_xfer  = in_valid_i && grant_q;
  assign out_xfer = valid_q && push_grant_i;
  assign new_word = encode(in_data_i, inject_err_i);

  // Next-state logic for the skid buffer. SKID only ever holds a word older
  // than anything newly accepted, so FIFO order is kept by always draining
  // SKID into OUT before new words can enter.
  always_comb begin
    state_next = state_q;
    out_next   = out_q;
    skid_next  = skid_q;
    count_next = count_q;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_next = ONE;
          out_next   = new_word;
        end
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_next = TWO;
          skid_next  = new_word;
        end else if (in_xfer && out_xfer) begin
          out_next   = new_word;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_next = ONE;
          out_next   = skid_q;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    if (out_xfer) begin
      count_next = count_q + 16'd1;
    end

    // The handshake outputs are precomputed from the next state. This lets
    // them come straight out of flops and change together with the state.
    valid_next = (state_next != EMPTY);
    grant_next = (state_next != TWO);
  end

  // State and output registers. Reset clears everything immediately,
  // including both held words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_next;
      out_q   <= out_next;
      skid_q  <= skid_next;
      count_q <= count_next;
      valid_q <= valid_next;
      grant_q <= grant_next;
    end
  end

  assign in_grant_o   = grant_q;
  assign push_data_o  = out_q;
  assign push_valid_o = valid_q;
  assign push_count_o = count_q;

endmodule

// File: tb/tb_parity_push_adapter.sv
// ---------------------------------------------------------------------------
// tb_parity_push_adapter
//
// Drives three adapter instances from the same stimulus. The instances differ
// only in parity sense and parity position. A queue-based reference model
// holds the expected in-flight words and the transfer count. It checks every
// instance on each falling edge. Directed tables and sequences cover
// encoding, reset, back-pressure, throughput and counter wrap.
// ---------------------------------------------------------------------------
module tb_parity_push_adapter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          inject_err;
  logic          push_grant;

  logic          grant_e0, valid_e0, grant_p1, valid_p1, grant_o0, valid_o0;
  logic [DW:0]   data_e0, data_p1, data_o0;
  logic [15:0]   count_e0, count_p1, count_o0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // even parity, parity at bit 0
  parity_push_adapter #(.DATA_WIDTH(DW), .EVEN_ODD(0), .PARITY_BIT(0)) dut (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .inject_err_i(inject_err), .in_grant_o(grant_e0), .push_data_o(data_e0),
    .push_valid_o(valid_e0), .push_grant_i(push_grant), .push_count_o(count_e0));

  // even parity, parity at the top bit
  parity_push_adapter #(.DATA_WIDTH(DW), .EVEN_ODD(0), .PARITY_BIT(1)) dut_p1 (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .inject_err_i(inject_err), .in_grant_o(grant_p1), .push_data_o(data_p1),
    .push_valid_o(valid_p1), .push_grant_i(push_grant), .push_count_o(count_p1));

  // odd parity, parity at bit 0
  parity_push_adapter #(.DATA_WIDTH(DW), .EVEN_ODD(1), .PARITY_BIT(0)) dut_o0 (
    .clk(clk), .rst(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .inject_err_i(inject_err), .in_grant_o(grant_o0), .push_data_o(data_o0),
    .push_valid_o(valid_o0), .push_grant_i(push_grant), .push_count_o(count_o0));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic inj, input logic g);
    in_valid   = v;
    in_data    = d;
    inject_err = inj;
    push_grant = g;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    repeat (3) stepCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reference encoding: count the ones and pick the parity bit so that the
  // total (including any injected flip) has the requested sense.
  function automatic logic [DW:0] ref_encode(input logic [DW-1:0] d, input logic inj,
                                             input int eo, input int pb);
    int   ones;
    logic p;
    ones = $countones(d) + int'(inj) + eo;
    p    = (ones % 2) == 1;
    if (pb == 0) return {d, p};
    else         return {p, d};
  endfunction

  // Reference model: an occupancy queue of raw {inject, data} records. The
  // block can accept while fewer than two words are held. Acceptance starts
  // only after the first clock edge out of reset.
  logic [DW:0] model_q[$];
  logic [15:0] model_count;
  bit          model_ready;
  bit          model_in_x, model_out_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_count = '0;
      model_ready = 1'b0;
    end else begin
      model_in_x  = in_valid && model_ready && (model_q.size() < 2);
      model_out_x = (model_q.size() > 0) && push_grant;
      if (model_out_x) begin
        void'(model_q.pop_front());
        model_count = model_count + 16'd1;
      end
      if (model_in_x) model_q.push_back({inject_err, in_data});
      model_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_valid", valid_e0, 0);
      checkOutput("rst_grant", grant_e0, 0);
      checkOutput("rst_data",  data_e0,  0);
      checkOutput("rst_count", count_e0, 0);
    end else begin
      checkOutput("sb_grant", grant_e0, model_ready && (model_q.size() < 2));
      checkOutput("sb_valid", valid_e0, model_q.size() > 0);
      checkOutput("sb_count", count_e0, model_count);
      checkOutput("sb_count_p1", count_p1, model_count);
      if (model_q.size() > 0) begin
        checkOutput("sb_data_e0", data_e0, ref_encode(model_q[0][DW-1:0], model_q[0][DW], 0, 0));
        checkOutput("sb_data_p1", data_p1, ref_encode(model_q[0][DW-1:0], model_q[0][DW], 0, 1));
        checkOutput("sb_data_o0", data_o0, ref_encode(model_q[0][DW-1:0], model_q[0][DW], 1, 0));
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          inj;
    logic [DW:0]   exp_e0;
    logic [DW:0]   exp_p1;
    logic [DW:0]   exp_o0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] got[$];
    logic [DW-1:0] src;
    int            n_acc, n_out, n_low, cyc;
    bit            acc;

    vecs[0] = '{32'h0000_0003, 1'b0, 33'h0_0000_0006, 33'h0_0000_0003, 33'h0_0000_0007};
    vecs[1] = '{32'h0000_0001, 1'b0, 33'h0_0000_0003, 33'h1_0000_0001, 33'h0_0000_0002};
    vecs[2] = '{32'h0000_0003, 1'b1, 33'h0_0000_0007, 33'h1_0000_0003, 33'h0_0000_0006};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF};
    vecs[4] = '{32'h8000_0000, 1'b0, 33'h1_0000_0001, 33'h1_8000_0000, 33'h1_0000_0000};
    vecs[5] = '{32'h0000_0000, 1'b1, 33'h0_0000_0001, 33'h1_0000_0000, 33'h0_0000_0000};

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #22 rst = 1'b0;
    #1 checkOutput("post_rst_grant_low", grant_e0, 0);
    stepCycle();
    checkOutput("post_rst_grant_high", grant_e0, 1);

    // Encoding table. A junk word with inject set but no valid follows each
    // accepted word; it must not disturb the word already held.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].inj, 1'b0);
      stepCycle();
      applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("tbl_valid", valid_e0, 1);
      checkOutput("tbl_e0", data_e0, vecs[i].exp_e0);
      checkOutput("tbl_p1", data_p1, vecs[i].exp_p1);
      checkOutput("tbl_o0", data_o0, vecs[i].exp_o0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      stepCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end

    // Back-pressure: stream 0x10.. while the FIFO withholds grant for three cycles.
    src = 32'h10; n_acc = 0; n_low = 0;
    for (int c = 0; c < 19; c++) begin
      applyStimulus(c < 15, src, 1'b0, !(c >= 3 && c <= 5));
      acc = in_valid && grant_e0;
      if (!grant_e0) n_low++;
      if (valid_e0 && push_grant) got.push_back(data_e0[DW:1]);
      stepCycle();
      if (acc) begin
        n_acc++;
        src++;
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("bp_accepted", n_acc, 12);
    checkOutput("bp_delivered", got.size(), 12);
    for (int i = 0; i < got.size(); i++) checkOutput("bp_order", got[i], 32'h10 + i);
    checkOutput("bp_grant_dropped", n_low > 0, 1);
    checkOutput("bp_grant_recovered", grant_e0, 1);
    checkOutput("bp_count", count_e0, 18);

    // Full throughput for 100 cycles.
    drain();
    n_out = 0; n_low = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1);
      if (valid_e0 && push_grant) n_out++;
      if (!grant_e0) n_low++;
      stepCycle();
    end
    checkOutput("tp_transfers", n_out, 99);
    checkOutput("tp_grant_never_low", n_low, 0);
    drain();

    // Reset with two words held.
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    stepCycle();
    checkOutput("two_held_grant", grant_e0, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", valid_e0, 0);
    checkOutput("async_rst_count", count_e0, 0);
    checkOutput("async_rst_data", data_e0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("rel_grant_low", grant_e0, 0);
    stepCycle();
    checkOutput("rel_grant_high", grant_e0, 1);
    checkOutput("rel_no_word", valid_e0, 0);
    stepCycle();
    checkOutput("rel_no_word_later", valid_e0, 0);

    // Randomized traffic, checked by the reference model.
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0, ($urandom % 3) != 0);
      stepCycle();
    end
    drain();

    // Counter wrap: 65537 transfers from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    stepCycle();
    n_out = 0; cyc = 0;
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b1);
    while (n_out < 65537 && cyc < 70000) begin
      in_data = $urandom;
      if (valid_e0 && push_grant) n_out++;
      stepCycle();
      cyc++;
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("wrap_transfers", n_out, 65537);
    @(negedge clk);
    checkOutput("wrap_count", count_e0, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
